// File: rtl/tnn_csr_pkg.sv
// Shared widths, FSM encoding and elaboration-time CSR helpers for tnn_csr_stream.
package tnn_csr_pkg;

    localparam int CSR_VEC_MAX = 2048;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_L2   = 3'd2,
        ST_ARG  = 3'd3,
        ST_DONE = 3'd4
    } tnn_state_e;

    function automatic int score_w(input int hidden_cnt);
        return $clog2(hidden_cnt + 1) + 1;
    endfunction

    function automatic int acc_w(input int feat_bits, input int feat_cnt);
        return feat_bits + $clog2(feat_cnt + 1) + 1;
    endfunction

    function automatic int csr_field(input logic [CSR_VEC_MAX-1:0] vec, input int idx, input int idx_bits);
        logic [CSR_VEC_MAX-1:0] field;
        field = (vec >> (idx * idx_bits)) & ~({CSR_VEC_MAX{1'b1}} << idx_bits);
        return int'(field[31:0]);
    endfunction

    // Packed ROM: field k (cls_w bits) holds the largest class c with row_ptrs[c] <= k.
    function automatic logic [CSR_VEC_MAX-1:0] csr_cls_rom(input logic [CSR_VEC_MAX-1:0] row_ptrs,
                                                           input int nnz, input int class_cnt,
                                                           input int idx_bits, input int cls_w);
        logic [CSR_VEC_MAX-1:0] rom;
        logic [CSR_VEC_MAX-1:0] cls_v;
        int cls;
        rom = '0;
        for (int k = 0; k < nnz; k++) begin
            cls = 0;
            for (int c = 0; c < class_cnt; c++) begin
                if (csr_field(row_ptrs, c, idx_bits) <= k) cls = c;
            end
            cls_v = CSR_VEC_MAX'(cls);
            rom = rom | (cls_v << (k * cls_w));
        end
        return rom;
    endfunction

    function automatic bit csr_ok(input logic [CSR_VEC_MAX-1:0] row_ptrs,
                                  input logic [CSR_VEC_MAX-1:0] col_idx,
                                  input int nnz, input int class_cnt,
                                  input int hidden_cnt, input int idx_bits);
        bit ok;
        ok = 1'b1;
        if (csr_field(row_ptrs, 0, idx_bits) != 0) ok = 1'b0;
        if (csr_field(row_ptrs, class_cnt, idx_bits) != nnz) ok = 1'b0;
        for (int c = 0; c < class_cnt; c++) begin
            if (csr_field(row_ptrs, c, idx_bits) > csr_field(row_ptrs, c + 1, idx_bits)) ok = 1'b0;
        end
        for (int k = 0; k < nnz; k++) begin
            if (csr_field(col_idx, k, idx_bits) >= hidden_cnt) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/tnn_l1_neuron.sv
// Combinational ternary dot product of the latched features with one MASK/VALS row.
module tnn_l1_neuron
    import tnn_csr_pkg::*;
#(
    parameter int FEAT_CNT  = 11,
    parameter int FEAT_BITS = 4
)(
    input  logic [FEAT_CNT*FEAT_BITS-1:0] feat,
    input  logic [FEAT_CNT-1:0]           mask_row,
    input  logic [FEAT_CNT-1:0]           vals_row,
    output logic                          hid_bit
);

    localparam int ACC_W = acc_w(FEAT_BITS, FEAT_CNT);

    logic signed [ACC_W-1:0] acc_s;
    logic signed [ACC_W-1:0] term_s;

    // Signed accumulation of +feat / -feat / 0 per feature.
    always_comb begin
        acc_s  = '0;
        term_s = '0;
        for (int f = 0; f < FEAT_CNT; f++) begin
            term_s = ACC_W'(feat[f*FEAT_BITS +: FEAT_BITS]);
            acc_s  = acc_s + (mask_row[f] ? (vals_row[f] ? term_s : -term_s) : '0);
        end
    end

    // Zero counts as non-negative, so it maps to +1.
    assign hid_bit = ~acc_s[ACC_W-1];

endmodule

// File: rtl/tnn_csr_stream.sv
// Streaming ternary classifier: dense L1, CSR-sparse L2, sequential argmax.
// Optional macro TNN_CSR_STREAM_SCORES_EN exposes the per-class scores port.
module tnn_csr_stream
    import tnn_csr_pkg::*;
#(
    parameter int FEAT_CNT   = 11,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 6,
    parameter int NNZ        = 71,
    parameter int IDX_BITS   = 8,
    parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]              MASK         = '1,
    parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]              VALS         = '0,
    parameter logic [((NNZ > 0) ? NNZ : 1)-1:0]            SPARSE_VALS2 = '0,
    parameter logic [((NNZ > 0) ? NNZ : 1)*IDX_BITS-1:0]   COL_INDICES  = '0,
    parameter logic [(CLASS_CNT+1)*IDX_BITS-1:0]           ROW_PTRS     =
        {8'd71, 8'd60, 8'd48, 8'd36, 8'd24, 8'd12, 8'd0}
)(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [FEAT_CNT*FEAT_BITS-1:0]          data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
`ifdef TNN_CSR_STREAM_SCORES_EN
    output logic [CLASS_CNT*score_w(HIDDEN_CNT)-1:0] scores,
`endif
    output logic [$clog2(CLASS_CNT)-1:0]           prediction
);

    localparam int SW    = score_w(HIDDEN_CNT);
    localparam int CLS_W = $clog2(CLASS_CNT);
    localparam int HW    = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
    localparam int NNZ_E = (NNZ > 0) ? NNZ : 1;
    localparam int KW    = (NNZ_E > 1) ? $clog2(NNZ_E) : 1;
    localparam logic [HW-1:0]        H_LAST  = HW'(HIDDEN_CNT - 1);
    localparam logic [KW-1:0]        K_LAST  = KW'(NNZ_E - 1);
    localparam logic [CLS_W-1:0]     C_LAST  = CLS_W'(CLASS_CNT - 1);
    localparam logic signed [SW-1:0] SC_INC  = SW'(1);
    localparam logic signed [SW-1:0] SC_DEC  = {SW{1'b1}};
    localparam logic [CSR_VEC_MAX-1:0] CLS_ROM =
        csr_cls_rom(CSR_VEC_MAX'(ROW_PTRS), NNZ, CLASS_CNT, IDX_BITS, CLS_W);

    if (!csr_ok(CSR_VEC_MAX'(ROW_PTRS), CSR_VEC_MAX'(COL_INDICES), NNZ, CLASS_CNT, HIDDEN_CNT, IDX_BITS)) begin : g_csr_bad
        $error("tnn_csr_stream: COL_INDICES/ROW_PTRS inconsistent with HIDDEN_CNT/NNZ");
    end

    tnn_state_e state_r, state_next_s;

    logic [FEAT_CNT*FEAT_BITS-1:0] feat_r;
    logic [HIDDEN_CNT-1:0]         hid_r;
    logic [HW-1:0]                 h_r;
    logic [KW-1:0]                 k_r;
    logic [CLS_W-1:0]              c_r;
    logic signed [SW-1:0]          score_r [CLASS_CNT];
    logic signed [SW-1:0]          best_score_r;
    logic [CLS_W-1:0]              best_idx_r;
    logic                          in_ready_r;
    logic                          out_valid_r;
    logic [CLS_W-1:0]              prediction_r;

    logic [FEAT_CNT-1:0]           mask_row_s;
    logic [FEAT_CNT-1:0]           vals_row_s;
    logic                          l1_pos_s;
    logic [CLS_W-1:0]              sel_cls_s;
    logic [IDX_BITS-1:0]           sel_col_s;
    logic                          sel_sign_s;
    logic                          hid_sel_s;
    logic                          match_s;
    logic signed [SW-1:0]          cur_score_s;

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign prediction = prediction_r;

    // Select the MASK/VALS row of the hidden neuron being evaluated.
    always_comb begin
        mask_row_s = '0;
        vals_row_s = '0;
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            mask_row_s = mask_row_s | ((h_r == HW'(h)) ? MASK[h*FEAT_CNT +: FEAT_CNT] : '0);
            vals_row_s = vals_row_s | ((h_r == HW'(h)) ? VALS[h*FEAT_CNT +: FEAT_CNT] : '0);
        end
    end

    tnn_l1_neuron #(
        .FEAT_CNT  (FEAT_CNT),
        .FEAT_BITS (FEAT_BITS)
    ) u_l1 (
        .feat     (feat_r),
        .mask_row (mask_row_s),
        .vals_row (vals_row_s),
        .hid_bit  (l1_pos_s)
    );

    // Non-zero k lookup: class from the constant ROM, hidden column and sign.
    always_comb begin
        sel_cls_s  = '0;
        sel_col_s  = '0;
        sel_sign_s = 1'b0;
        hid_sel_s  = 1'b0;
        for (int k = 0; k < NNZ; k++) begin
            sel_cls_s  = sel_cls_s  | ((k_r == KW'(k)) ? CLS_ROM[k*CLS_W +: CLS_W] : '0);
            sel_col_s  = sel_col_s  | ((k_r == KW'(k)) ? COL_INDICES[k*IDX_BITS +: IDX_BITS] : '0);
            sel_sign_s = sel_sign_s | ((k_r == KW'(k)) & SPARSE_VALS2[k]);
        end
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            hid_sel_s = hid_sel_s | ((sel_col_s == IDX_BITS'(h)) & hid_r[h]);
        end
        match_s = ~(sel_sign_s ^ hid_sel_s);
    end

    // Score of the class currently visited by the argmax scan.
    always_comb begin
        cur_score_s = '0;
        for (int c = 0; c < CLASS_CNT; c++) begin
            cur_score_s = cur_score_s | ((c_r == CLS_W'(c)) ? score_r[c] : '0);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) state_next_s = ST_L1;
                else                        state_next_s = ST_IDLE;
            end
            ST_L1: begin
                if (h_r == H_LAST) state_next_s = (NNZ == 0) ? ST_ARG : ST_L2;
                else               state_next_s = ST_L1;
            end
            ST_L2: begin
                if (k_r == K_LAST) state_next_s = ST_ARG;
                else               state_next_s = ST_L2;
            end
            ST_ARG: begin
                if (c_r == C_LAST) state_next_s = ST_DONE;
                else               state_next_s = ST_ARG;
            end
            ST_DONE: begin
                if (out_valid_r && out_ready) state_next_s = ST_IDLE;
                else                          state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_next_s;
    end

    // Datapath: feature latch, hidden bits, sparse scoring, argmax and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feat_r       <= '0;
            hid_r        <= '0;
            h_r          <= '0;
            k_r          <= '0;
            c_r          <= '0;
            best_score_r <= '0;
            best_idx_r   <= '0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            prediction_r <= '0;
            for (int c = 0; c < CLASS_CNT; c++) score_r[c] <= '0;
        end else begin
            in_ready_r <= (state_next_s == ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        feat_r <= data;
                        h_r    <= '0;
                        k_r    <= '0;
                        c_r    <= '0;
                        for (int c = 0; c < CLASS_CNT; c++) score_r[c] <= '0;
                    end
                end
                ST_L1: begin
                    for (int h = 0; h < HIDDEN_CNT; h++) begin
                        if (h_r == HW'(h)) hid_r[h] <= l1_pos_s;
                    end
                    h_r <= h_r + 1'b1;
                end
                ST_L2: begin
                    for (int c = 0; c < CLASS_CNT; c++) begin
                        if (sel_cls_s == CLS_W'(c)) score_r[c] <= score_r[c] + (match_s ? SC_INC : SC_DEC);
                    end
                    k_r <= k_r + 1'b1;
                end
                ST_ARG: begin
                    // Strictly-greater replacement keeps the lowest index on ties.
                    if (c_r == '0) begin
                        best_score_r <= cur_score_s;
                        best_idx_r   <= '0;
                    end else if (cur_score_s > best_score_r) begin
                        best_score_r <= cur_score_s;
                        best_idx_r   <= c_r;
                    end
                    c_r <= c_r + 1'b1;
                end
                ST_DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r  <= 1'b1;
                        prediction_r <= best_idx_r;
                    end else if (out_ready) begin
                        out_valid_r  <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef TNN_CSR_STREAM_SCORES_EN
    // Flatten the score registers onto the optional port.
    always_comb begin
        scores = '0;
        for (int c = 0; c < CLASS_CNT; c++) scores[c*SW +: SW] = score_r[c];
    end
`endif

endmodule

// File: tb/tb_tnn_csr_stream.sv
// Directed self-checking bench for tnn_csr_stream (sparse config and an NNZ=0 config).
module tb_tnn_csr_stream;

    localparam int SW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic       in_valid_z = 1'b0, in_ready_z, out_valid_z, out_ready_z = 1'b0;
    logic [0:0] prediction, prediction_z;
`ifdef TNN_CSR_STREAM_SCORES_EN
    logic [2*SW-1:0] scores, scores_z;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    tnn_csr_stream #(
        .FEAT_CNT(2), .FEAT_BITS(4), .HIDDEN_CNT(2), .CLASS_CNT(2), .NNZ(3), .IDX_BITS(8),
        .MASK(4'b1111), .VALS(4'b0101), .SPARSE_VALS2(3'b011),
        .COL_INDICES({8'd1, 8'd1, 8'd0}), .ROW_PTRS({8'd3, 8'd2, 8'd0})
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data(data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef TNN_CSR_STREAM_SCORES_EN
        .scores(scores),
`endif
        .prediction(prediction)
    );

    tnn_csr_stream #(
        .FEAT_CNT(2), .FEAT_BITS(4), .HIDDEN_CNT(2), .CLASS_CNT(2), .NNZ(0), .IDX_BITS(8),
        .MASK(4'b1111), .VALS(4'b0101), .SPARSE_VALS2(1'b0),
        .COL_INDICES(8'd0), .ROW_PTRS({8'd0, 8'd0, 8'd0})
    ) dut_z (
        .clk(clk), .rst(rst), .in_valid(in_valid_z), .in_ready(in_ready_z), .data(data),
        .out_valid(out_valid_z), .out_ready(out_ready_z),
`ifdef TNN_CSR_STREAM_SCORES_EN
        .scores(scores_z),
`endif
        .prediction(prediction_z)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on either instance: accept, measure latency, check, hand off.
    task automatic run_vec(input bit z, input logic [7:0] d, input int exp_pred,
                           input int exp_lat, input string tag);
        int n;
        n = 0;
        while (((z ? in_ready_z : in_ready) == 1'b0) && n < 50) begin tick(); n++; end
        chk({tag, "_rdy"}, int'(z ? in_ready_z : in_ready), 1);
        data = d;
        if (z) in_valid_z = 1'b1;
        else   in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        in_valid_z = 1'b0;
        n = 0;
        while (((z ? out_valid_z : out_valid) == 1'b0) && n < 50) begin tick(); n++; end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_pred"}, int'(z ? prediction_z : prediction), exp_pred);
        if (z) out_ready_z = 1'b1;
        else   out_ready   = 1'b1;
        tick();
        out_ready = 1'b0;
        out_ready_z = 1'b0;
        chk({tag, "_ovlo"}, int'(z ? out_valid_z : out_valid), 0);
        chk({tag, "_irdy"}, int'(z ? in_ready_z : in_ready), 1);
    endtask

    initial begin
        int n, t0, t1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_pred", int'(prediction), 0);
        chk("rst_z_in_ready", int'(in_ready_z), 1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // feat0 in low nibble, feat1 in high nibble
        run_vec(1'b0, 8'h35, 0, 8, "t1_5_3");
        run_vec(1'b0, 8'h53, 1, 8, "t2_3_5");
        run_vec(1'b0, 8'h77, 0, 8, "t3_7_7");
        run_vec(1'b1, 8'h35, 0, 5, "t4_tie_a");
        run_vec(1'b1, 8'h53, 0, 5, "t4_tie_b");

        // Hold the result with out_ready low while in_valid pulses are offered.
        data = 8'h35;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        chk("t5_lat", n, 8);
        for (int i = 0; i < 10; i++) begin
            data = 8'h53;
            in_valid = (i % 2 == 0);
            tick();
            chk("t5_hold_ov", int'(out_valid), 1);
            chk("t5_hold_pred", int'(prediction), 0);
            chk("t5_hold_irdy", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t5_rel_ov", int'(out_valid), 0);
        chk("t5_rel_irdy", int'(in_ready), 1);

        // Back-to-back with out_ready held high: period is latency+2.
        data = 8'h35;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        t0 = cyc;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        chk("t5_b2b_pred1", int'(prediction), 0);
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        data = 8'h53;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        t1 = cyc;
        chk("t5_b2b_gap", t1 - t0, 10);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        chk("t5_b2b_lat2", n, 8);
        chk("t5_b2b_pred2", int'(prediction), 1);
        tick();
        out_ready = 1'b0;
        chk("t5_b2b_ovlo", int'(out_valid), 0);

        // Reset in the middle of L2.
        data = 8'h53;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_ov", int'(out_valid), 0);
        chk("t6_rst_irdy", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) n++;
        end
        out_ready = 1'b0;
        chk("t6_no_partial", n, 0);
        run_vec(1'b0, 8'h53, 1, 8, "t6_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tnn_csr_stream.md
Name: tnn_csr_stream

Overview:
- Next-generation sequential ternary classifier with a streaming valid/ready interface; replaces one-shot product wrappers around the fixed sequential core.
- Layer 1: dense ternary (MASK/VALS) over unsigned features, one hidden neuron per cycle.
- Layer 2: CSR-sparse ternary over hidden bits, one non-zero per cycle. Sequential argmax produces the prediction.
- Sits between the feature source and the result consumer; one inference in flight.

Parameters:
FEAT_CNT, 11, number of input features
FEAT_BITS, 4, unsigned bits per feature
HIDDEN_CNT, 40, hidden neurons
CLASS_CNT, 6, output classes
NNZ, 71, layer-2 non-zero count (0 allowed)
IDX_BITS, 8, bits per COL_INDICES / ROW_PTRS entry
MASK, HIDDEN_CNT*FEAT_CNT bits, layer-1 non-zero mask; weight (h,f) at bit h*FEAT_CNT+f
VALS, HIDDEN_CNT*FEAT_CNT bits, layer-1 sign where mask=1 (1=+1, 0=-1)
SPARSE_VALS2, max(NNZ,1) bits, layer-2 sign per non-zero k at bit k
COL_INDICES, NNZ*IDX_BITS, hidden index of non-zero k at [k*IDX_BITS +: IDX_BITS]
ROW_PTRS, (CLASS_CNT+1)*IDX_BITS, entry c = first k of class c; entry 0 = 0, last = NNZ

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  feature vector valid
in_ready  out  1  block can accept
data  in  FEAT_CNT*FEAT_BITS  feature f at [f*FEAT_BITS +: FEAT_BITS], unsigned
out_valid  out  1  prediction valid
out_ready  in  1  consumer accepts prediction
prediction  out  $clog2(CLASS_CNT)  winning class index

Behaviour:
- Reset: asynchronous, active-high. State=IDLE, in_ready=1, out_valid=0, prediction=0; hidden bits and scores cleared.
- Reset mid-inference aborts the inference; no partial result is ever presented.
- States: IDLE -> L1 -> L2 -> ARG -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch data, h=0, clear scores, go to L1. in_ready=0 in every other state.
- L1 (HIDDEN_CNT cycles): acc = sum over f of w(h,f)*feat_f, where w is +1, -1 or 0.
  - acc is signed, width FEAT_BITS+$clog2(FEAT_CNT+1)+1, so it never overflows.
  - hid[h] = (acc >= 0), so zero maps to +1.
  - After h = HIDDEN_CNT-1, go to L2, or to ARG if NNZ = 0.
- L2 (NNZ cycles, k = 0..NNZ-1):
  - Class index cls(k) comes from an elaboration-time constant ROM: largest c with ROW_PTRS[c] <= k. Empty rows are therefore skipped at no cycle cost.
  - score[cls] += (sign_k XNOR hid[col_k]) ? +1 : -1.
  - score is signed, width $clog2(HIDDEN_CNT+1)+1.
- ARG (CLASS_CNT cycles): sequential scan c = 0..CLASS_CNT-1 keeping best; replace only on strictly greater score, so ties resolve to the lowest index. Then go to DONE.
- DONE: out_valid=1; prediction is stable until out_valid&out_ready; then go to IDLE.
  - out_ready may already be high on entry.
  - in_ready rises the cycle after the output handshake.
- Latency: out_valid rises exactly HIDDEN_CNT+NNZ+CLASS_CNT+1 cycles after the input handshake. Throughput is one inference per latency+2 cycles minimum.
- in_valid while busy is ignored; the data is not sampled.
- COL_INDICES >= HIDDEN_CNT, or ROW_PTRS that are non-monotonic or inconsistent with NNZ: elaboration-time $error.

Optional Feature:
- Macro TNN_CSR_STREAM_SCORES_EN.
- Defined: extra output port scores, width CLASS_CNT*SCORE_W, class c at [c*SCORE_W +: SCORE_W], two's complement. Valid and stable whenever out_valid=1; zero after reset.
- Undefined: port absent, no extra logic; scores remain internal registers only.

Decomposition:
- Package tnn_csr_pkg:
  - SCORE_W / ACC_W width functions.
  - State enum typedef (IDLE, L1, L2, ARG, DONE).
  - Function building the cls(k) ROM from ROW_PTRS.
  - CSR consistency-check function.
- One sub-module tnn_l1_neuron: combinational ternary dot product of latched features with one MASK/VALS row, output acc sign bit. The FSM, L2 update and argmax stay in the top module.

Test Plan:
Common config unless stated: FEAT_CNT=2, HIDDEN_CNT=2, CLASS_CNT=2, FEAT_BITS=4, MASK=4'b1111, VALS=4'b0101, NNZ=3, ROW_PTRS={3,2,0}, COL_INDICES={1,1,0}, SPARSE_VALS2=3'b011.
1. feat0=5, feat1=3: hid={1,1}, scores {+2,-1} -> prediction=0; out_valid exactly 8 cycles after accept.
2. feat0=3, feat1=5: scores {-2,+1} -> prediction=1.
3. feat0=feat1=7: acc=0 gives hid=1 -> prediction=0.
4. Tie: NNZ=0, ROW_PTRS={0,0,0} -> all scores 0, prediction=0, latency 5.
5. Handshake: hold out_ready=0 for 10 cycles -> prediction stable, in_ready=0, in_valid pulses ignored; release -> in_ready=1 next cycle; back-to-back vectors 1 then 2 give 0 then 1.
6. Assert rst during L2 -> out_valid=0, in_ready=1 immediately; next vector gives the correct result.
